// File: rtl/parity_arbiter_pkg.sv
// Shared types and constants for parity_arbiter: FSM state encoding,
// error-counter ceiling, and the requester-index width helper.
package parity_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        RESULT = 2'd2
    } state_e;

    localparam logic [7:0] ERRCNT_MAX = 8'hFF;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req bit scanning upward
// from last+1 with wrap, returned both one-hot and as an index.
module rr_pick
    import parity_arbiter_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win_onehot,
    output logic [IW-1:0]   win_idx
);

    logic [IW-1:0] cand;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        cand    = '0;
        win_idx = '0;
        // Walk from farthest to nearest so the nearest requester after 'last' wins.
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
        win_onehot = (req != '0) ? (NREQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one reduction-parity unit among NREQ requesters.
// Optional per-result parity check and error counter: PARITY_ARBITER_ERRCNT_EN.
module parity_arbiter
    import parity_arbiter_pkg::*;
#(
    parameter int  NREQ = 4,
    parameter int  DW   = 8,
    localparam int IW   = id_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IW-1:0]      res_id,
    output logic               odd_parity,
    output logic               even_parity
`ifdef PARITY_ARBITER_ERRCNT_EN
    ,
    input  logic [NREQ-1:0]    exp_odd,
    output logic               par_err,
    output logic [7:0]         err_cnt
`endif
);

    state_e          state;
    state_e          state_nxt;
    logic [DW-1:0]   data_q;
    logic [IW-1:0]   id_q;
    logic [IW-1:0]   last;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic [DW-1:0]   pick_word;
    logic            capture;
    logic            calc_odd;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last       (last),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_word = data[i*DW +: DW];
            end
        end
    end

    assign capture  = (state == IDLE) && (req != '0);
    assign calc_odd = ^data_q;
    assign busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != '0) state_nxt = CALC;
            CALC:    state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture in IDLE, compute in CALC, hold the result in RESULT until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt         <= '0;
            data_q      <= '0;
            id_q        <= '0;
            last        <= IW'(NREQ - 1);
            res_valid   <= 1'b0;
            res_id      <= '0;
            odd_parity  <= 1'b0;
            even_parity <= 1'b1;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        data_q <= pick_word;
                        id_q   <= pick_idx;
                        last   <= pick_idx;
                        gnt    <= pick_onehot;
                    end
                end
                CALC: begin
                    odd_parity  <= calc_odd;
                    even_parity <= ~calc_odd;
                    res_id      <= id_q;
                    res_valid   <= 1'b1;
                end
                RESULT: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef PARITY_ARBITER_ERRCNT_EN
    logic exp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q   <= 1'b0;
            par_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) exp_q <= exp_odd[pick_idx];
                end
                CALC: begin
                    par_err <= (calc_odd != exp_q);
                    if ((calc_odd != exp_q) && (err_cnt != ERRCNT_MAX)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                RESULT: begin
                    if (res_ready) par_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Scoreboard bench for parity_arbiter: a transaction-level model predicts grants
// and results; a negedge monitor compares DUT outputs against the queue.
module tb_parity_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] data = '0;
    logic               res_ready = 1'b0;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               res_valid;
    logic [IW-1:0]      res_id;
    logic               odd_parity;
    logic               even_parity;
`ifdef PARITY_ARBITER_ERRCNT_EN
    logic [NREQ-1:0]    exp_odd = '0;
    logic               par_err;
    logic [7:0]         err_cnt;
    int                 exp_cnt = 0;
`endif

    always #5 clk = ~clk;

    parity_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .data        (data),
        .gnt         (gnt),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .odd_parity  (odd_parity),
        .even_parity (even_parity)
`ifdef PARITY_ARBITER_ERRCNT_EN
        ,
        .exp_odd     (exp_odd),
        .par_err     (par_err),
        .err_cnt     (err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one word in flight at a time; grant appears the cycle
    // after capture, the result the cycle after that, and stays until taken.
    typedef struct {
        int id;
        bit odd;
        bit perr;
    } res_t;

    res_t            res_q[$];
    bit              in_flight = 1'b0;
    int              age = 0;
    int              last_w = NREQ - 1;
    int              cur_w = 0;
    bit              cur_perr = 1'b0;
    logic [NREQ-1:0] exp_gnt = '0;
    bit              exp_valid = 1'b0;
    bit              exp_busy = 1'b0;
    bit              fresh_reset = 1'b1;

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int prev);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(prev + k) % NREQ]) return (prev + k) % NREQ;
        end
        return -1;
    endfunction

    initial forever begin
        logic [DW-1:0] word;
        res_t          r;
        @(posedge clk);
        if (!rst_n) begin
            in_flight   = 1'b0;
            last_w      = NREQ - 1;
            fresh_reset = 1'b1;
            res_q.delete();
`ifdef PARITY_ARBITER_ERRCNT_EN
            exp_cnt = 0;
`endif
        end else if (in_flight) begin
            if (age >= 1 && res_ready) begin
                in_flight = 1'b0;
            end else begin
`ifdef PARITY_ARBITER_ERRCNT_EN
                if (age == 0 && cur_perr && exp_cnt < 255) exp_cnt++;
`endif
                age++;
            end
        end else if (req != '0) begin
            cur_w    = rr_winner(req, last_w);
            last_w   = cur_w;
            word     = data[cur_w*DW +: DW];
            cur_perr = 1'b0;
`ifdef PARITY_ARBITER_ERRCNT_EN
            cur_perr = ((^word) != exp_odd[cur_w]);
`endif
            r.id   = cur_w;
            r.odd  = ^word;
            r.perr = cur_perr;
            res_q.push_back(r);
            in_flight = 1'b1;
            age       = 0;
        end
        exp_gnt   = (in_flight && age == 0) ? (NREQ'(1) << cur_w) : '0;
        exp_valid = in_flight && (age >= 1);
        exp_busy  = in_flight;
        if (exp_valid) fresh_reset = 1'b0;
    end

    // Monitor: mid-cycle compare; pops the scoreboard when the result is taken.
    initial forever begin
        res_t r;
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("res_valid", 32'(res_valid), 32'(exp_valid));
        check("busy", 32'(busy), 32'(exp_busy));
`ifdef PARITY_ARBITER_ERRCNT_EN
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
        if (exp_valid) begin
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: result expected but queue empty (t=%0t)", $time);
            end else begin
                r = res_q[0];
                check("res_id", 32'(res_id), 32'(r.id));
                check("odd_parity", 32'(odd_parity), 32'(r.odd));
                check("even_parity", 32'(even_parity), 32'(!r.odd));
`ifdef PARITY_ARBITER_ERRCNT_EN
                check("par_err", 32'(par_err), 32'(r.perr));
`endif
                if (res_ready) void'(res_q.pop_front());
            end
        end else begin
`ifdef PARITY_ARBITER_ERRCNT_EN
            check("par_err_idle", 32'(par_err), 32'd0);
`endif
            if (fresh_reset) begin
                check("rst_odd", 32'(odd_parity), 32'd0);
                check("rst_even", 32'(even_parity), 32'd1);
                check("rst_id", 32'(res_id), 32'd0);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // Random requesters: a granted requester drops or re-arms with a new word.
    task automatic random_cycle(input int p_req, input int p_ready);
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                if ($urandom_range(1, 0) == 0) begin
                    req[i] = 1'b0;
                end else begin
                    data[i*DW +: DW] = DW'($urandom);
`ifdef PARITY_ARBITER_ERRCNT_EN
                    exp_odd[i] = 1'($urandom_range(1, 0));
`endif
                end
            end else if (!req[i] && $urandom_range(99, 0) < p_req) begin
                req[i]           = 1'b1;
                data[i*DW +: DW] = DW'($urandom);
`ifdef PARITY_ARBITER_ERRCNT_EN
                exp_odd[i] = 1'($urandom_range(1, 0));
`endif
            end
        end
        res_ready = ($urandom_range(99, 0) < p_ready);
    endtask

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};

        // Reset held two cycles with everyone requesting.
        req       = 4'b1111;
        data      = {8'hFF, 8'hF0, 8'hAA, 8'h01};
        res_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) cycle();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_even_direct", 32'(even_parity), 32'd1);
        rst_n = 1'b1;

        // All requesting: grants 0,1,2,3,0 exactly three cycles apart.
        cycle();
        check("all_gnt0", 32'(gnt), 32'd1);
        for (int g = 1; g < 5; g++) begin
            repeat (3) cycle();
            check("all_gnt_order", 32'(gnt), 32'(1 << order[g]));
        end
        req = '0;
        repeat (4) cycle();

        // Single request from requester 2.
        req  = 4'b0100;
        data = {8'h00, 8'h03, 8'h00, 8'h00};
        cycle();
        check("single_gnt", 32'(gnt), 32'b0100);
        req = '0;
        cycle();
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_id", 32'(res_id), 32'd2);
        check("single_odd", 32'(odd_parity), 32'd0);
        check("single_even", 32'(even_parity), 32'd1);
        repeat (2) cycle();

        // Backpressure: result frozen, no new grant while held.
        req       = 4'b0001;
        data      = {8'h00, 8'h00, 8'h00, 8'h07};
        res_ready = 1'b0;
        cycle();
        check("bp_gnt", 32'(gnt), 32'b0001);
        req = 4'b0011;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_gnt", 32'(gnt), 32'd0);
            check("bp_hold_odd", 32'(odd_parity), 32'd1);
        end
        res_ready = 1'b1;
        cycle();
        check("bp_release_valid", 32'(res_valid), 32'd0);
        cycle();
        check("bp_next_gnt", 32'(gnt), 32'b0010);
        req = '0;
        repeat (4) cycle();

        // Reset during CALC discards the in-flight word.
        req  = 4'b1000;
        data = {8'hAA, 8'h00, 8'h00, 8'h00};
        cycle();
        check("midrst_gnt", 32'(gnt), 32'b1000);
        rst_n = 1'b0;
        req   = '0;
        cycle();
        check("midrst_valid", 32'(res_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) cycle();
        req = 4'b1001;
        cycle();
        check("midrst_prio0", 32'(gnt), 32'b0001);
        req = '0;
        repeat (4) cycle();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            random_cycle(30, 70);
        end
        req       = '0;
        res_ready = 1'b1;
        repeat (6) cycle();

`ifdef PARITY_ARBITER_ERRCNT_EN
        // Parity mismatches: first one counts 0->1, then saturate.
        rst_n   = 1'b0;
        exp_odd = '0;
        repeat (2) cycle();
        rst_n = 1'b1;
        req   = 4'b0010;
        data  = {8'h00, 8'h00, 8'h07, 8'h00};
        repeat (2) cycle();
        check("err_par_err", 32'(par_err), 32'd1);
        check("err_cnt_first", 32'(err_cnt), 32'd1);
        repeat (920) cycle();
        req = '0;
        repeat (6) cycle();
        check("err_cnt_sat", 32'(err_cnt), 32'hFF);
`endif

        check("drain_q", 32'(res_q.size()), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_arbiter.md
Name: parity_arbiter

Overview:
- Shares one reduction-parity datapath between NREQ requesters, each presenting a DW-bit word.
- Round-robin arbitration, a registered grant pulse, and a registered result with a valid/ready handshake toward the consumer.
- Sits between requesting blocks and the shared parity unit; owns all sequencing of that unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per requester (>=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  NREQ  req[i]=1: requester i has a word pending.
- data  input  NREQ*DW  requester i word at data[i*DW +: DW]; held stable while req[i]=1.
- gnt  output  NREQ  one-hot, one-cycle pulse: word from requester i was captured.
- busy  output  1  1 in any state other than IDLE.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_id  output  $clog2(NREQ)  index of requester owning the result.
- odd_parity  output  1  1 if the captured word has an odd number of 1s.
- even_parity  output  1  always ~odd_parity while res_valid=1.

Behaviour:
- FSM states:
  - IDLE -> CALC: at an edge where any req=1.
  - CALC -> RESULT: unconditional, one cycle.
  - RESULT -> IDLE: at an edge where res_valid & res_ready.
- Capture (IDLE edge with req!=0):
  - winner w = first set req bit scanning from (last+1) mod NREQ upward, with wrap.
  - Registered at that edge: data_q <= word w, id_q <= w, last <= w, gnt <= onehot(w).
- gnt is high only during the CALC cycle. Requester i drops or changes req[i]/data after seeing gnt[i].
- CALC edge registers:
  - odd_parity <= ^data_q; even_parity <= ~^data_q.
  - res_id <= id_q; res_valid <= 1.
- Result hold: res_valid, res_id and both parity outputs stay stable until accepted. res_valid drops on the edge after acceptance.
- Latency: request seen in IDLE cycle T -> gnt in T+1 -> res_valid in T+2. Minimum 3 cycles per word with res_ready tied high; next grant no earlier than the IDLE cycle T+3.
- No new capture outside IDLE. req changes during CALC/RESULT are ignored.
- Fairness: a continuously requesting requester waits at most NREQ-1 other grants.
- Reset (rst_n=0 at an edge), including mid-operation:
  - state <= IDLE; gnt, res_valid, odd_parity, res_id, data_q <= 0; even_parity <= 1.
  - last <= NREQ-1, so requester 0 has top priority after reset.
  - In-flight word is discarded; the requester must re-request.
- res_ready while res_valid=0 is ignored.
- req=0 in IDLE: outputs hold and the FSM stays in IDLE.

Optional Feature:
- Macro: PARITY_ARBITER_ERRCNT_EN.
- When defined, adds:
  - input exp_odd[NREQ-1:0]: expected parity per requester, captured with the word.
  - output par_err (1): registered with the result; 1 when odd_parity != captured exp_odd[w]; cleared with res_valid.
  - output err_cnt (8): saturates at 8'hFF, increments once per mismatching result at the CALC edge, reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package parity_arbiter_pkg: state encoding constants (IDLE=2'd0, CALC=2'd1, RESULT=2'd2), ERRCNT_MAX=8'hFF, id-width function.
- Sub-module rr_pick: purely combinational; inputs req and last, output one-hot winner plus index.
- Parity computation stays inline as a reduction XOR.

Test Plan:
- Reset with req=4'b1111 and rst_n=0 for 2 cycles -> gnt=0, res_valid=0, even_parity=1. First grant after release is gnt=4'b0001.
- Single request: req=4'b0100, data[23:16]=8'h03 -> gnt=4'b0100 at T+1; res_valid at T+2 with res_id=2, odd=0, even=1.
- All requesting, res_ready=1:
  - words 8'h01, 8'hAA, 8'hF0, 8'hFF.
  - Grant order 0,1,2,3,0.
  - odd results 1,0,0,0,1.
  - Grants spaced 3 cycles apart.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> outputs frozen, no new gnt. Raising res_ready gives res_valid=0 on the next edge and the next grant after that.
- Reset mid-operation: rst_n=0 during CALC -> next cycle IDLE with res_valid=0. The in-flight word is never reported.
- With PARITY_ARBITER_ERRCNT_EN: requester 1 sends 8'h07 with exp_odd=0 -> par_err=1, err_cnt 0->1. After 300 mismatches err_cnt=8'hFF.
